bar_level_fsm: RTL
==================

Name: bar_level_fsm

Overview:
Parametrised successor to the team's 9-state bar-graph LED FSM. Holds a level of 0..NUM_LEVELS that moves one step per enable pulse. The level drives an LED output in one of three display/step modes: thermometer bar, single dot, or auto-bounce. Adds selectable wrap/saturate at the ends, a parallel load, end-of-range flags and a wrap event pulse. Sits between the board pulse/debounce logic and the LED bank.

Parameters:
NUM_LEVELS, 8, number of non-zero levels; level range is 0..NUM_LEVELS; must be >= 2.
LEDS_PER_LEVEL, 2, LEDs lit per level step.
(derived) LW = $clog2(NUM_LEVELS+1), the level width; OW = NUM_LEVELS*LEDS_PER_LEVEL, the LED width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
pulse  in  1  step enable; level-sensitive, so the block steps on every clk edge where pulse=1.
cnt_up  in  1  direction in BAR/DOT modes: 1 = up, 0 = down.
wrap_en  in  1  1 = wrap at the ends, 0 = saturate at the ends (BAR/DOT only).
mode  in  2  0 = BAR, 1 = DOT, 2 = BOUNCE, 3 = reserved (behaves as BAR).
load  in  1  parallel load strobe.
load_level  in  LW  value to load.
out  out  OW  LED pattern.
level  out  LW  current level.
at_min  out  1  level == 0.
at_max  out  1  level == NUM_LEVELS.
wrapped  out  1  one-cycle pulse on a wrap event.

Behaviour:
- Single clock domain. reset is synchronous and active-high, sampled on the rising edge of clk.
- Registered state: level, dir (1 = up), wrapped.
- Reset values: level = 0, dir = up (1), wrapped = 0. After reset: out = 0, at_min = 1, at_max = 0.
- Priority on each edge: reset > load > pulse > hold.
- Load:
  - level <= min(load_level, NUM_LEVELS).
  - dir unchanged; wrapped <= 0.
  - pulse is ignored in the same cycle.
- Step, BAR/DOT modes (when pulse=1):
  - Up, level < NUM_LEVELS: level+1.
  - Up, level == NUM_LEVELS: with wrap_en=1, level <= 0 and wrapped <= 1; with wrap_en=0, hold.
  - Down, level > 0: level-1.
  - Down, level == 0: with wrap_en=1, level <= NUM_LEVELS and wrapped <= 1; with wrap_en=0, hold.
- Step, BOUNCE mode (when pulse=1; cnt_up and wrap_en ignored):
  - dir up and level < NUM_LEVELS: level+1.
  - dir up and level == NUM_LEVELS: dir <= down, level <= NUM_LEVELS-1.
  - dir down and level > 0: level-1.
  - dir down and level == 0: dir <= up, level <= 1.
  - wrapped is never set in BOUNCE.
- wrapped is 0 in every cycle that did not register a wrap, so it is a single-cycle pulse.
- Decode is combinational from level and mode, giving zero latency from state to out and the flags:
  - BAR/reserved: bits [level*LEDS_PER_LEVEL-1:0] = 1, all other bits 0.
  - DOT: level 0 gives all zeros; level k >= 1 lights only bits [(k-1)*LEDS_PER_LEVEL +: LEDS_PER_LEVEL].
  - BOUNCE: displays as BAR.
- A mode change takes effect on out immediately. level and dir are preserved across mode changes.
- No default/illegal level is reachable: load clamps, and the step logic never exceeds the range.
- Reset mid-sequence: level is 0 at the next edge regardless of pulse or load.

Decomposition:
- Shared package bar_pkg:
  - mode constants MODE_BAR = 2'd0, MODE_DOT = 2'd1, MODE_BOUNCE = 2'd2, MODE_RSVD = 2'd3;
  - DIR_UP = 1'b1, DIR_DN = 1'b0.
- One sub-module, bar_decoder: purely combinational, level+mode -> out. It is parametrised identically and is reusable by other LED displays.
- The FSM/step logic and flags stay in bar_level_fsm.

Test Plan:
(All scenarios use defaults NUM_LEVELS=8, LEDS_PER_LEVEL=2, OW=16.)
1. Reset; mode=0, cnt_up=1, wrap_en=1; 9 single-cycle pulses -> out steps 0x0003, 0x000F, 0x003F, 0x00FF, 0x03FF, 0x0FFF, 0x3FFF, 0xFFFF, then 0x0000. wrapped=1 only in the cycle after the 9th pulse; at_max=1 at level 8.
2. wrap_en=0: at level 8, pulse with cnt_up=1 -> level stays 8, wrapped=0. At level 0, pulse with cnt_up=0 -> level stays 0, at_min=1.
3. wrap_en=1, level 0, cnt_up=0, one pulse -> level=8, out=0xFFFF, wrapped=1 for one cycle. pulse held high for 3 cycles from level 8 down -> level 5.
4. mode=1: load 3 -> out=0x0030; load 8 -> out=0xC000; load 0 -> out=0x0000. Switching to mode=0 at level 3 -> out=0x003F with level unchanged.
5. mode=2 from reset, 11 pulses -> level sequence 1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5 with wrapped constantly 0. A further 5 pulses -> 0, then 1 (dir flips at 0).
6. load=1, load_level=12, pulse=1 in the same cycle -> level=8 (clamped, no step). reset asserted together with load/pulse -> level=0, out=0, wrapped=0 at the next edge.

Source files
------------

// File: rtl/bar_pkg.sv
// bar_pkg: shared mode and direction constants for LED bar displays
package bar_pkg;
  localparam logic [1:0] MODE_BAR    = 2'd0;
  localparam logic [1:0] MODE_DOT    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;
  typedef enum logic {DIR_DN = 1'b0, DIR_UP = 1'b1} dir_t;
endpackage

// File: rtl/bar_decoder.sv
// bar_decoder: combinational level+mode to LED pattern (bar or single dot)
module bar_decoder
  import bar_pkg::*;
#(
  parameter int NUM_LEVELS     = 8,
  parameter int LEDS_PER_LEVEL = 2,
  localparam int LW = $clog2(NUM_LEVELS + 1),
  localparam int OW = NUM_LEVELS * LEDS_PER_LEVEL
) (
  input  logic [LW-1:0] level,
  input  logic [1:0]    mode,
  output logic [OW-1:0] out
);
  int  hi;
  logic dot;
  assign hi  = int'(level) * LEDS_PER_LEVEL;
  assign dot = mode == MODE_DOT;
  // light bits below hi; in dot mode only the top group of LEDS_PER_LEVEL
  always_comb begin
    out = '0;
    for (int i = 0; i < OW; i++) out[i] = (i < hi) && (dot ? i >= hi - LEDS_PER_LEVEL : 1'b1);
  end
endmodule

// File: rtl/bar_level_fsm.sv
// bar_level_fsm: stepped level counter with wrap/saturate/bounce driving an LED bar
module bar_level_fsm
  import bar_pkg::*;
#(
  parameter int NUM_LEVELS     = 8,
  parameter int LEDS_PER_LEVEL = 2,
  localparam int LW = $clog2(NUM_LEVELS + 1),
  localparam int OW = NUM_LEVELS * LEDS_PER_LEVEL
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pulse,
  input  logic          cnt_up,
  input  logic          wrap_en,
  input  logic [1:0]    mode,
  input  logic          load,
  input  logic [LW-1:0] load_level,
  output logic [OW-1:0] out,
  output logic [LW-1:0] level,
  output logic          at_min,
  output logic          at_max,
  output logic          wrapped
);
  localparam logic [LW-1:0] MAX = LW'(NUM_LEVELS);
  localparam logic [LW-1:0] ONE = LW'(1);
  dir_t dir, dir_nx;
  logic [LW-1:0] level_nx;
  logic wrapped_nx, up, top, bot;
  assign top    = level == MAX;
  assign bot    = level == '0;
  assign at_min = bot;
  assign at_max = top;
  assign up     = mode == MODE_BOUNCE ? dir == DIR_UP : cnt_up;
  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      level   <= '0;
      dir     <= DIR_UP;
      wrapped <= 1'b0;
    end else begin
      level   <= level_nx;
      dir     <= dir_nx;
      wrapped <= wrapped_nx;
    end
  end
  // next state: load beats pulse; bounce reflects at the ends, other modes wrap or saturate
  always_comb begin
    level_nx   = level;
    dir_nx     = dir;
    wrapped_nx = 1'b0;
    if (load) level_nx = load_level > MAX ? MAX : load_level;
    else if (pulse) begin
      if (mode == MODE_BOUNCE) begin
        level_nx = up ? (top ? MAX - ONE : level + ONE) : (bot ? ONE : level - ONE);
        dir_nx   = up ? (top ? DIR_DN : DIR_UP) : (bot ? DIR_UP : DIR_DN);
      end else if (up ? top : bot) begin
        level_nx   = wrap_en ? (up ? '0 : MAX) : level;
        wrapped_nx = wrap_en;
      end else level_nx = up ? level + ONE : level - ONE;
    end
  end
  bar_decoder #(.NUM_LEVELS(NUM_LEVELS), .LEDS_PER_LEVEL(LEDS_PER_LEVEL)) u_dec (
    .level(level),
    .mode (mode),
    .out  (out)
  );
endmodule
